// File: rtl/div_stream_ctrl.sv
// Streaming front-end for a fixed-latency, non-stallable divider: registers operands,
// tracks in-flight ops and buffers quotients in a FIFO sized so it can never overflow.
// Optional divide-by-zero flagging is enabled by defining DIV_STREAM_DBZ_EN.
module div_stream_ctrl #(
    parameter int DATA_LEN    = 32,
    parameter int DIV_LATENCY = 11,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_LEN-1:0]           in_a,
    input  logic [DATA_LEN-1:0]           in_b,
    output logic [DATA_LEN-1:0]           div_a,
    output logic [DATA_LEN-1:0]           div_b,
    input  logic [DATA_LEN-1:0]           div_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_LEN-1:0]           out_result,
    output logic                          out_dbz,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic                accept;
    logic                push;
    logic                pop;
    logic [AW:0]         occ_q;
    logic [AW:0]         fifo_cnt;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [DATA_LEN-1:0] div_a_q;
    logic [DATA_LEN-1:0] div_b_q;
    logic [DIV_LATENCY:0] vld_pipe;
    logic [DATA_LEN-1:0] push_data;
    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];

    // Occupancy counts in-flight ops too, so a slot is reserved for every accept.
    assign in_ready  = !reset && (occ_q < DEPTH_C);
    assign out_valid = !reset && (fifo_cnt != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push      = vld_pipe[DIV_LATENCY];

    assign div_a      = reset ? '0 : div_a_q;
    assign div_b      = reset ? '0 : div_b_q;
    assign occupancy  = reset ? '0 : occ_q;
    assign out_result = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_a_q  <= '0;
            div_b_q  <= '0;
            vld_pipe <= '0;
            occ_q    <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (accept) begin
                div_a_q <= in_a;
                div_b_q <= in_b;
            end
            vld_pipe <= {vld_pipe[DIV_LATENCY-1:0], accept};
            occ_q    <= occ_q + (AW+1)'(accept) - (AW+1)'(pop);
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

`ifdef DIV_STREAM_DBZ_EN
    logic [DIV_LATENCY:0]  dbz_pipe;
    logic [FIFO_DEPTH-1:0] dbz_mem;

    always_ff @(posedge clk) begin
        if (reset) dbz_pipe <= '0;
        else       dbz_pipe <= {dbz_pipe[DIV_LATENCY-1:0], accept && (in_b == '0)};
        if (push) dbz_mem[wr_ptr] <= dbz_pipe[DIV_LATENCY];
    end

    // Divider output is meaningless for b == 0; substitute a fixed marker.
    assign push_data = dbz_pipe[DIV_LATENCY] ? '1 : div_result;
    assign out_dbz   = out_valid && dbz_mem[rd_ptr];
`else
    assign push_data = div_result;
    assign out_dbz   = 1'b0;
`endif

endmodule
